// File: rtl/cambus_pkg.sv
// Shared types and default geometry for the camera bus retimer.
package cambus_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } lock_state_t;

  localparam int DEF_H_START  = 1;
  localparam int DEF_H_ACTIVE = 320;
  localparam int DEF_V_START  = 1;
  localparam int DEF_V_ACTIVE = 256;

endpackage

// File: rtl/cambus_lockdet.sv
// Line-length lock detector: measures events between hsync edges and
// declares lock after LOCK_LINES consecutive matching lines.
module cambus_lockdet
  import cambus_pkg::*;
#(
  parameter int CNT_W      = 10,
  parameter int LOCK_LINES = 4,
  parameter int TIMEOUT    = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic ev,
  input  logic hs_edge,
  output logic locked
);
  localparam int TO_W   = $clog2(TIMEOUT + 1);
  localparam int GOOD_W = $clog2(LOCK_LINES + 1);

  lock_state_t       state;
  logic [CNT_W-1:0]  len_cnt, len_ref;
  logic [TO_W-1:0]   idle;
  logic [GOOD_W-1:0] good;
  logic              timeout, len_ok;

  // idle reaches TIMEOUT-1 on the TIMEOUT-th consecutive cycle without an event
  assign timeout = !ev && (idle == TO_W'(TIMEOUT - 1));
  assign len_ok  = (len_cnt == len_ref);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= UNLOCKED;
      len_cnt <= '0;
      len_ref <= '0;
      idle    <= '0;
      good    <= '0;
      locked  <= 1'b0;
    end else if (timeout) begin
      state   <= UNLOCKED;
      len_cnt <= '0;
      idle    <= '0;
      good    <= '0;
      locked  <= 1'b0;
    end else if (ev) begin
      idle <= '0;
      if (hs_edge) begin
        len_cnt <= CNT_W'(1);
        case (state)
          UNLOCKED: begin
            len_ref <= len_cnt;
            good    <= '0;
            state   <= ACQUIRE;
          end
          ACQUIRE: begin
            if (!len_ok) state <= UNLOCKED;
            else if (good == GOOD_W'(LOCK_LINES - 1)) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end else good <= good + 1'b1;
          end
          LOCKED: begin
            if (!len_ok) begin
              state  <= UNLOCKED;
              locked <= 1'b0;
            end
          end
          default: begin
            state  <= UNLOCKED;
            locked <= 1'b0;
          end
        endcase
      end else if (len_cnt != '1) begin
        len_cnt <= len_cnt + 1'b1;
      end
    end else begin
      idle <= idle + 1'b1;
    end
  end

endmodule

// File: rtl/cambus_retime.sv
// Camera bus retimer: synchronises a slow parallel camera into clk, tracks
// pixel/line position and gates output to the visible window once locked.
// Optional CAMBUS_TEST_PATTERN_EN replaces visible pixels with a ramp.
module cambus_retime
  import cambus_pkg::*;
#(
  parameter int PIX_W       = 12,
  parameter int SYNC_STAGES = 3,
  parameter int CNT_W       = 10,
  parameter int H_START     = DEF_H_START,
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int V_START     = DEF_V_START,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int CLK_EDGE    = 0,
  parameter int LOCK_LINES  = 4,
  parameter int TIMEOUT     = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cam_clk,
  input  logic [PIX_W-1:0] cam_pixel,
  input  logic             cam_hsync,
  input  logic             cam_vsync,
  input  logic             show_test_pattern,
  output logic [PIX_W-1:0] vid_pixel,
  output logic             vid_pixsync,
  output logic             vid_hblank,
  output logic             vid_vblank,
  output logic             vid_visible,
  output logic             vid_locked,
  output logic [CNT_W-1:0] vid_line
);
  localparam int SW    = PIX_W + 3;
  localparam int H_END = H_START + H_ACTIVE;
  localparam int V_END = V_START + V_ACTIVE;
  localparam logic [CNT_W:0] H_LO = H_START[CNT_W:0];
  localparam logic [CNT_W:0] H_HI = H_END[CNT_W:0];
  localparam logic [CNT_W:0] V_LO = V_START[CNT_W:0];
  localparam logic [CNT_W:0] V_HI = V_END[CNT_W:0];

  logic [SYNC_STAGES-1:0][SW-1:0] sync;
  logic [SW-1:0]    s_last;
  logic             clk_d, cam_edge, ev, hs_q, vs_q, hs_prev, vs_prev, seen;
  logic             hs_edge, vs_edge, locked;
  logic [PIX_W-1:0] pix_q, pix_src, pixel_q;
  logic [CNT_W-1:0] pix_cnt, line_cnt, pix_n, line_n;
  logic             frame_ok, fok_n, h_vis, v_vis, vis_q, pixsync, hblank, vblank;

  assign s_last   = sync[SYNC_STAGES-1];
  assign cam_edge = (CLK_EDGE == 0) ? (s_last[SW-1] & ~clk_d) : (~s_last[SW-1] & clk_d);
  // seen masks the first event after reset, which has no previous sample
  assign hs_edge  = ev & seen & hs_q & ~hs_prev;
  assign vs_edge  = ev & seen & vs_q & ~vs_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync    <= '0;
      clk_d   <= 1'b0;
      ev      <= 1'b0;
      {vs_q, hs_q, pix_q} <= '0;
      hs_prev <= 1'b0;
      vs_prev <= 1'b0;
      seen    <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], {cam_clk, cam_vsync, cam_hsync, cam_pixel}};
      clk_d <= s_last[SW-1];
      ev    <= cam_edge;
      if (cam_edge) {vs_q, hs_q, pix_q} <= s_last[SW-2:0];
      if (ev) begin
        hs_prev <= hs_q;
        vs_prev <= vs_q;
        seen    <= 1'b1;
      end
    end
  end

  cambus_lockdet #(
    .CNT_W      (CNT_W),
    .LOCK_LINES (LOCK_LINES),
    .TIMEOUT    (TIMEOUT)
  ) u_lockdet (
    .clk     (clk),
    .rst     (rst),
    .ev      (ev),
    .hs_edge (hs_edge),
    .locked  (locked)
  );

  always_comb begin
    pix_n  = '0;
    line_n = '0;
    fok_n  = 1'b0;
    if (locked) begin
      pix_n  = (pix_cnt != '1) ? pix_cnt + 1'b1 : pix_cnt;
      line_n = line_cnt;
      if (hs_edge) begin
        pix_n = '0;
        if (line_cnt != '1) line_n = line_cnt + 1'b1;
      end
      if (vs_edge) line_n = '0;
      fok_n = frame_ok | vs_edge;
    end
  end

  assign h_vis = ({1'b0, pix_n} >= H_LO) && ({1'b0, pix_n} < H_HI);
  assign v_vis = ({1'b0, line_n} >= V_LO) && ({1'b0, line_n} < V_HI);

`ifdef CAMBUS_TEST_PATTERN_EN
  assign pix_src = show_test_pattern
                 ? (PIX_W'(pix_n) - PIX_W'(H_START)) + (PIX_W'(line_n) - PIX_W'(V_START))
                 : pix_q;
`else
  logic unused_tp;
  assign unused_tp = show_test_pattern;
  assign pix_src   = pix_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_cnt  <= '0;
      line_cnt <= '0;
      frame_ok <= 1'b0;
      pixsync  <= 1'b0;
      pixel_q  <= '0;
      vis_q    <= 1'b0;
      hblank   <= 1'b1;
      vblank   <= 1'b1;
    end else begin
      pixsync <= ev;
      if (!locked) begin
        pix_cnt  <= '0;
        line_cnt <= '0;
        frame_ok <= 1'b0;
      end else if (ev) begin
        pix_cnt  <= pix_n;
        line_cnt <= line_n;
        frame_ok <= fok_n;
      end
      if (ev) begin
        pixel_q <= pix_src;
        vis_q   <= h_vis & v_vis & locked & fok_n;
        hblank  <= !h_vis;
        vblank  <= !v_vis;
      end
    end
  end

  // locked gating makes a reset or lock loss blank the output at once
  assign vid_visible = vis_q & locked;
  assign vid_pixel   = vid_visible ? pixel_q : '0;
  assign vid_pixsync = pixsync;
  assign vid_hblank  = hblank;
  assign vid_vblank  = vblank;
  assign vid_locked  = locked;
  assign vid_line    = line_cnt;

endmodule
